// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Owns the program counter and fetches one instruction at a time from an
//   instruction memory that answers with a variable number of cycles of
//   latency. The fetched instruction is held stable for the datapath until the
//   core loads a new PC through en_pc/updated_pc. If memory never answers, a
//   sticky fetch_error is raised and the unit freezes until reset.
//
// Ports:
//   clk                     in   1   system clock, rising edge
//   rst_n                   in   1   asynchronous active-low reset
//   run                     in   1   core run enable
//   mem_req                 out  1   read request to instruction memory
//   mem_addr                out  16  read address (current_pc)
//   mem_ready               in   1   memory accepts the request this cycle
//   mem_rvalid              in   1   read data valid
//   mem_rdata               in   16  read data
//   updated_pc              in   16  next PC from the PC-update logic
//   en_pc                   in   1   load updated_pc into the PC
//   instruction_from_memory out  16  held instruction
//   current_pc              out  16  PC of the held instruction
//   instr_valid             out  1   instruction_from_memory is valid
//   fetch_error             out  1   sticky memory-timeout flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] updated_pc,
  input  logic        en_pc,
  output logic [15:0] instruction_from_memory,
  output logic [15:0] current_pc,
  output logic        instr_valid,
  output logic        fetch_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_ERROR
  } fetch_state_t;

  // The counter holds the number of WAIT cycles already spent without data,
  // so the last permitted WAIT cycle is the one where it equals TIMEOUT-1.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic        valid_q;
  logic        err_q;
  logic [15:0] cnt_q;

  logic capture;
  logic advance;
  logic cnt_clr;
  logic cnt_inc;
  logic set_err;

  // State register. Reset drops straight back to IDLE, which abandons any
  // outstanding read: a late rvalid lands outside WAIT and is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode. In WAIT, data arriving on the final
  // permitted cycle is checked before the timeout, so data wins the tie.
  // An accepted request always proceeds to WAIT even if run has dropped,
  // because memory has already committed to answering.
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    capture = 1'b0;
    advance = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    set_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          state_d = ST_WAIT;
          cnt_clr = 1'b1;
        end else if (!run) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          set_err = 1'b1;
          state_d = ST_ERROR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_HOLD: begin
        if (en_pc) begin
          advance = 1'b1;
          state_d = run ? ST_REQ : ST_IDLE;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath registers. The PC only moves on an advance out of HOLD, and the
  // instruction register is cleared on that same edge so stale instructions
  // are never presented alongside the new PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      if (cnt_clr) begin
        cnt_q <= 16'h0000;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 16'd1;
      end

      if (capture) begin
        instr_q <= mem_rdata;
        valid_q <= 1'b1;
      end else if (advance) begin
        pc_q    <= updated_pc;
        instr_q <= 16'h0000;
        valid_q <= 1'b0;
      end

      if (set_err) begin
        err_q   <= 1'b1;
        valid_q <= 1'b0;
      end
    end
  end

  // The address is simply the PC; it is only meaningful while mem_req is high.
  assign mem_addr                = pc_q;
  assign current_pc              = pc_q;
  assign instruction_from_memory = instr_q;
  assign instr_valid             = valid_q;
  assign fetch_error             = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. The bench plays both the
// instruction memory and the core: it decides when memory accepts and answers
// and when the core advances the PC, so the expected outputs follow directly
// from the transaction it just performed (expected PC, returned data).
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          TIMEOUT  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] updated_pc = 16'h0000;
  logic        en_pc = 1'b0;

  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] instruction_from_memory;
  logic [15:0] current_pc;
  logic        instr_valid;
  logic        fetch_error;

  int errors = 0;
  int checks = 0;

  // Reference model state: the PC the unit should currently be presenting.
  logic [15:0] model_pc = RESET_PC;

  instr_fetch_unit #(
    .RESET_PC      (RESET_PC),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .run                    (run),
    .mem_req                (mem_req),
    .mem_addr               (mem_addr),
    .mem_ready              (mem_ready),
    .mem_rvalid             (mem_rvalid),
    .mem_rdata              (mem_rdata),
    .updated_pc             (updated_pc),
    .en_pc                  (en_pc),
    .instruction_from_memory(instruction_from_memory),
    .current_pc             (current_pc),
    .instr_valid            (instr_valid),
    .fetch_error            (fetch_error)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pc"}, current_pc, RESET_PC);
    checkOutput({tag, "_instr"}, instruction_from_memory, 16'h0000);
    checkOutput({tag, "_valid"}, instr_valid, 1'b0);
    checkOutput({tag, "_req"}, mem_req, 1'b0);
    checkOutput({tag, "_err"}, fetch_error, 1'b0);
  endtask

  // Assert reset off-edge, check outputs at once, release on a falling edge.
  task automatic applyReset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues(tag);
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    en_pc      = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    model_pc = RESET_PC;
  endtask

  // One complete fetch transaction. Entry: the unit is in a REQ cycle.
  // Exit: the unit is again in a REQ cycle, at model_pc == new_pc.
  task automatic applyStimulus(input int ready_delay, input int lat,
                               input logic [15:0] data, input int hold_cycles,
                               input logic [15:0] new_pc, input bit run_after,
                               input bit drop_run, input bit junk);
    int hs = 0;
    int idle_cycles;
    checkOutput("req_mem_req", mem_req, 1'b1);
    checkOutput("req_addr", mem_addr, model_pc);
    checkOutput("req_valid", instr_valid, 1'b0);

    for (int i = 0; i < ready_delay; i++) begin
      run        = 1'b1;
      mem_ready  = 1'b0;
      en_pc      = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      updated_pc = 16'($urandom);
      mem_rvalid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata  = 16'($urandom);
      if (mem_req && mem_ready) hs++;
      tick();
      checkOutput("req_stall_req", mem_req, 1'b1);
      checkOutput("req_stall_addr", mem_addr, model_pc);
    end

    // Handshake cycle; junk rvalid here is a zero-latency response to ignore.
    mem_ready  = 1'b1;
    mem_rvalid = junk;
    mem_rdata  = 16'($urandom);
    en_pc      = junk;
    updated_pc = 16'($urandom);
    if (mem_req && mem_ready) hs++;
    tick();
    mem_ready = 1'b0;

    for (int w = 1; w <= lat; w++) begin
      checkOutput("wait_req", mem_req, 1'b0);
      checkOutput("wait_valid", instr_valid, 1'b0);
      checkOutput("wait_err", fetch_error, 1'b0);
      if (drop_run) run = 1'b0;
      en_pc      = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      updated_pc = 16'($urandom);
      mem_rvalid = (w == lat);
      mem_rdata  = (w == lat) ? data : 16'($urandom);
      if (mem_req && mem_ready) hs++;
      tick();
    end
    mem_rvalid = 1'b0;
    checkOutput("handshakes", hs, 1);

    for (int h = 0; h <= hold_cycles; h++) begin
      checkOutput("hold_valid", instr_valid, 1'b1);
      checkOutput("hold_instr", instruction_from_memory, data);
      checkOutput("hold_pc", current_pc, model_pc);
      checkOutput("hold_req", mem_req, 1'b0);
      if (h < hold_cycles) begin
        en_pc      = 1'b0;
        run        = 1'($urandom_range(0, 1));
        updated_pc = 16'($urandom);
        mem_rvalid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata  = 16'($urandom);
        tick();
      end
    end

    en_pc      = 1'b1;
    updated_pc = new_pc;
    run        = run_after;
    mem_rvalid = 1'b0;
    tick();
    en_pc    = 1'b0;
    model_pc = new_pc;
    checkOutput("adv_pc", current_pc, new_pc);
    checkOutput("adv_valid", instr_valid, 1'b0);
    checkOutput("adv_instr", instruction_from_memory, 16'h0000);

    if (run_after) begin
      checkOutput("adv_req", mem_req, 1'b1);
    end else begin
      checkOutput("adv_idle_req", mem_req, 1'b0);
      idle_cycles = $urandom_range(1, 3);
      for (int k = 0; k < idle_cycles; k++) begin
        run        = 1'b0;
        en_pc      = 1'($urandom_range(0, 1));
        updated_pc = 16'($urandom);
        mem_rvalid = 1'($urandom_range(0, 1));
        tick();
        checkOutput("idle_req", mem_req, 1'b0);
        checkOutput("idle_pc", current_pc, model_pc);
      end
      en_pc      = 1'b0;
      mem_rvalid = 1'b0;
      run        = 1'b1;
      tick();
    end
  endtask

  // Memory never answers; the error must appear after exactly TIMEOUT waits.
  task automatic runTimeout();
    checkOutput("to_req", mem_req, 1'b1);
    run       = 1'b1;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int w = 1; w <= TIMEOUT; w++) begin
      checkOutput("to_err_early", fetch_error, 1'b0);
      checkOutput("to_wait_req", mem_req, 1'b0);
      mem_rvalid = 1'b0;
      tick();
    end
    checkOutput("to_err", fetch_error, 1'b1);
    checkOutput("to_err_valid", instr_valid, 1'b0);
    for (int k = 0; k < 5; k++) begin
      en_pc      = 1'b1;
      updated_pc = 16'($urandom);
      run        = 1'b1;
      mem_ready  = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 16'($urandom);
      tick();
      checkOutput("err_sticky", fetch_error, 1'b1);
      checkOutput("err_req", mem_req, 1'b0);
      checkOutput("err_valid", instr_valid, 1'b0);
      checkOutput("err_pc", current_pc, model_pc);
      checkOutput("err_instr", instruction_from_memory, 16'h0000);
    end
    en_pc      = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         rd, lt, hc;
    logic [15:0] npc;
    bit          ra, dr, jk;

    // Power-on reset.
    #12;
    checkResetValues("por");
    @(negedge clk);
    rst_n    = 1'b1;
    model_pc = RESET_PC;

    // Minimum-latency fetch from reset.
    run = 1'b1;
    checkOutput("c0_req", mem_req, 1'b0);
    tick();
    applyStimulus(0, 1, 16'h0051, 0, 16'h0001, 1'b1, 1'b0, 1'b0);

    // Stalled acceptance, multi-cycle latency, long hold.
    applyStimulus(4, 3, 16'h1234, 10, 16'h0002, 1'b1, 1'b0, 1'b0);

    // Branch instruction redirecting the PC.
    applyStimulus(0, 2, 16'h0A32, 2, 16'h00A3, 1'b1, 1'b0, 1'b0);

    // Request withdrawn when run drops before acceptance.
    run       = 1'b0;
    mem_ready = 1'b0;
    tick();
    checkOutput("withdraw_req", mem_req, 1'b0);
    tick();
    checkOutput("withdraw_idle_req", mem_req, 1'b0);
    run = 1'b1;
    tick();

    // Run dropped during WAIT: read completes, then the unit idles.
    applyStimulus(1, 4, 16'h5A5A, 2, 16'h00A4, 1'b0, 1'b1, 1'b0);

    // Data on the final permitted WAIT cycle beats the timeout.
    applyStimulus(0, TIMEOUT, 16'hC3C3, 1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    applyStimulus(2, 1, 16'h7777, 0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      rd  = $urandom_range(0, 4);
      lt  = $urandom_range(1, TIMEOUT);
      hc  = $urandom_range(0, 5);
      npc = 16'($urandom);
      ra  = ($urandom_range(0, 3) != 0);
      dr  = ($urandom_range(0, 3) == 0);
      jk  = 1'($urandom_range(0, 1));
      applyStimulus(rd, lt, 16'($urandom), hc, npc, ra, dr, jk);
    end

    // Reset mid-WAIT followed by a stale response.
    run       = 1'b1;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    applyReset("midwait_rst");
    run = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hFFFF;
    checkOutput("stale_req", mem_req, 1'b1);
    tick();
    mem_rvalid = 1'b0;
    checkOutput("stale_valid", instr_valid, 1'b0);
    checkOutput("stale_instr", instruction_from_memory, 16'h0000);
    checkOutput("stale_pc", current_pc, RESET_PC);
    applyStimulus(0, 2, 16'h4242, 1, 16'h0010, 1'b1, 1'b0, 1'b0);

    // Timeout, stickiness, and recovery through reset.
    runTimeout();
    applyReset("err_rst");
    run = 1'b1;
    tick();
    applyStimulus(1, 1, 16'h0BEE, 0, 16'h0020, 1'b1, 1'b0, 1'b0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Supplies the datapath with `instruction_from_memory` and `current_pc`. It consumes `updated_pc` and `en_pc` from the PC-update/branch logic. It owns the PC register and runs a request/response handshake with instruction memory that tolerates variable latency. The fetched instruction is held stable until the core signals PC advance.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles without `mem_rvalid` before a fetch error (1..65535).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  core run enable.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  16  read address; equals `current_pc` while `mem_req`=1.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  16  read data.
- updated_pc  in  16  next PC from the PC-update logic.
- en_pc  in  1  load `updated_pc` into the PC.
- instruction_from_memory  out  16  held instruction; [1:0] format, [3:2] branch condition, [15:4] target.
- current_pc  out  16  PC of the held instruction.
- instr_valid  out  1  `instruction_from_memory` is valid.
- fetch_error  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (async assert, sync release):
  - `current_pc`=RESET_PC.
  - `instruction_from_memory`=16'h0000.
  - `instr_valid`=0, `mem_req`=0, `fetch_error`=0.
  - Timeout counter=0, state=IDLE.
  - Reset mid-fetch abandons the transaction; any later `mem_rvalid` is ignored until the next request.
- States: IDLE, REQ, WAIT, HOLD, ERROR.
- IDLE:
  - `mem_req`=0.
  - `run`=1 -> REQ next cycle.
- REQ:
  - `mem_req`=1, `mem_addr`=`current_pc`.
  - `mem_ready`=1 -> WAIT; timeout counter cleared.
  - `run`=0 with `mem_ready`=0 -> IDLE, request withdrawn.
  - `run`=0 with `mem_ready`=1 -> handshake completes; go to WAIT.
- WAIT:
  - `mem_req`=0.
  - `mem_rvalid`=1 -> capture `mem_rdata` into the instruction register; `instr_valid`=1 from next cycle; -> HOLD.
  - The outstanding read always completes regardless of `run`.
  - Counter increments each cycle without `rvalid`. On reaching TIMEOUT_CYCLES, `fetch_error`=1 -> ERROR.
  - `rvalid` on the same cycle the counter hits the limit: data wins, no error.
- HOLD:
  - Instruction and `current_pc` are stable.
  - `en_pc`=1 -> `current_pc`<=`updated_pc` (loaded verbatim, no arithmetic here; wrap of 16'hFFFF+1 to 0 is the producer's job).
  - Same edge: `instr_valid`<=0 and instruction register <=16'h0000.
  - Next state is REQ if `run`=1, else IDLE.
  - `en_pc`=0: remain in HOLD indefinitely; `run` deassertion alone does not leave HOLD.
- ERROR:
  - All outputs frozen except `mem_req`=0 and `instr_valid`=0.
  - Exit only via `rst_n`.
- `en_pc` is ignored in every state except HOLD; `current_pc` never changes outside HOLD.
- `mem_rvalid` is ignored outside WAIT.
- Minimum fetch latency:
  - REQ with `mem_ready` at cycle N.
  - `rvalid` at N+1.
  - `instr_valid`=1 at N+2.
  - PC advance at the first HOLD cycle with `en_pc`.
  - Next `mem_req` on the cycle after that.
- Zero-latency responses (`rvalid` in the same cycle as `mem_ready`) are not supported and are ignored.

Test Plan:
1. Reset with RESET_PC=16'h0000, `run`=1, memory ready and 1-cycle latency returning 16'h0051:
   - `mem_req` at cycle 1, `mem_addr`=0.
   - `instr_valid` at cycle 3 with instruction 16'h0051.
   - `en_pc` with `updated_pc`=16'h0001 -> `current_pc`=1 next cycle and a new request to address 1.
2. Hold `mem_ready` low 4 cycles, then high; `rvalid` after 3 cycles:
   - `mem_addr` is stable throughout.
   - Exactly one handshake occurs.
   - Instruction captured once and held unchanged while `en_pc`=0 for 10 cycles.
3. Branch instruction 16'h0A32 (format 10), `en_pc` with `updated_pc`=16'h00A3 -> `current_pc`=16'h00A3 and the next `mem_addr`=16'h00A3.
4. TIMEOUT_CYCLES=8, `rvalid` withheld:
   - `fetch_error`=1 exactly 8 cycles after the handshake.
   - `mem_req` stays 0 and `en_pc` is ignored.
   - Cleared only by `rst_n`.
5. Deassert `run` in WAIT:
   - Read completes and the instruction is held.
   - `en_pc` advances the PC, then the unit goes to IDLE with no new `mem_req` until `run` rises.
6. Assert `rst_n`=0 asynchronously mid-WAIT, then release; a stale `rvalid` with 16'hFFFF arrives one cycle after release:
   - Outputs are at reset values immediately.
   - The stale data is ignored and `instr_valid` stays 0.
